// File: rtl/crc_pkg.sv
// Shared types, mode constants, bit reflection and preset parameter sets for the
// streaming CRC engine.
package crc_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_DATA   = 2'd1,
      ST_APPEND = 2'd2
   } crc_state_e;

   localparam bit MODE_APPEND = 1'b0;
   localparam bit MODE_CHECK  = 1'b1;

   // CRC-8 (poly 0x1D, reflected), check value 0x97
   localparam int unsigned CRC8_W       = 8;
   localparam logic [7:0]  CRC8_POLY    = 8'h1D;
   localparam logic [7:0]  CRC8_INIT    = 8'hFF;
   localparam bit          CRC8_REFIN   = 1'b1;
   localparam bit          CRC8_REFOUT  = 1'b1;
   localparam logic [7:0]  CRC8_XOROUT  = 8'h00;
   localparam logic [7:0]  CRC8_RESIDUE = 8'h00;

   // CRC-16/CCITT-FALSE, check value 0x29B1
   localparam int unsigned CRC16_W       = 16;
   localparam logic [15:0] CRC16_POLY    = 16'h1021;
   localparam logic [15:0] CRC16_INIT    = 16'hFFFF;
   localparam bit          CRC16_REFIN   = 1'b0;
   localparam bit          CRC16_REFOUT  = 1'b0;
   localparam logic [15:0] CRC16_XOROUT  = 16'h0000;
   localparam logic [15:0] CRC16_RESIDUE = 16'h0000;

   // CRC-32 (IEEE 802.3), check value 0xCBF43926
   localparam int unsigned CRC32_W       = 32;
   localparam logic [31:0] CRC32_POLY    = 32'h04C1_1DB7;
   localparam logic [31:0] CRC32_INIT    = 32'hFFFF_FFFF;
   localparam bit          CRC32_REFIN   = 1'b1;
   localparam bit          CRC32_REFOUT  = 1'b1;
   localparam logic [31:0] CRC32_XOROUT  = 32'hFFFF_FFFF;
   localparam logic [31:0] CRC32_RESIDUE = 32'hDEBB_20E3;

   // Reverse the low w bits of v; bits above w come back as zero.
   function automatic logic [31:0] reflect(input logic [31:0] v, input int unsigned w);
      logic [31:0] r;
      r = '0;
      for (int unsigned i = 0; i < 32; i++) begin
         if (i < w) r[5'(i)] = v[5'(w - 1 - i)];
      end
      return r;
   endfunction

endpackage

// File: rtl/crc_stream_step.sv
// One full byte step of an MSB-first CRC register: XOR the byte into the top
// and apply eight LFSR shifts.
module crc_byte_step #(
   parameter int unsigned      CRC_W = 8,
   parameter logic [CRC_W-1:0] POLY  = CRC_W'(8'h1D)
) (
   input  logic [CRC_W-1:0] i_crc,
   input  logic [7:0]       i_byte,
   output logic [CRC_W-1:0] o_crc_c
);

   always_comb begin
      o_crc_c = i_crc ^ (CRC_W'(i_byte) << (CRC_W - 8));
      for (int i = 0; i < 8; i++) begin
         if (o_crc_c[CRC_W-1]) o_crc_c = (o_crc_c << 1) ^ POLY;
         else                  o_crc_c = o_crc_c << 1;
      end
   end

endmodule

// File: rtl/crc_stream.sv
// Streaming CRC engine with valid/ready flow control: APPEND mode emits the CRC
// after each frame, CHECK mode flags a received codeword good or bad.
module crc_stream
   import crc_pkg::*;
#(
   parameter int unsigned      CRC_W   = 8,
   parameter logic [CRC_W-1:0] POLY    = CRC_W'(8'h1D),
   parameter logic [CRC_W-1:0] INIT    = CRC_W'(8'hFF),
   parameter bit               REFIN   = 1'b1,
   parameter bit               REFOUT  = 1'b1,
   parameter logic [CRC_W-1:0] XOROUT  = CRC_W'(8'h00),
   parameter logic [CRC_W-1:0] RESIDUE = CRC_W'(8'h00),
   parameter bit               MODE    = MODE_APPEND
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             axiiv,
   input  logic [7:0]       axiid,
   input  logic             axiil,
   output logic             axiir,
   output logic             axiov,
   output logic [7:0]       axiod,
   output logic             axiol,
   input  logic             axior,
   output logic [CRC_W-1:0] crc_value,
   output logic             crc_ok,
   output logic             crc_err
);

   localparam int unsigned NB    = CRC_W / 8;
   localparam int unsigned CNT_W = 3;

   crc_state_e       r_state, w_state_nxt;
   logic             r_started;
   logic [CRC_W-1:0] r_crc, w_crc_nxt;
   logic [CRC_W-1:0] r_crc_value, w_crc_value_nxt;
   logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
   logic             r_axiov, w_axiov_nxt;
   logic [7:0]       r_axiod, w_axiod_nxt;
   logic             r_axiol, w_axiol_nxt;
   logic             r_crc_ok, w_crc_ok_nxt;
   logic             r_crc_err, w_crc_err_nxt;

   logic             w_slot_free;
   logic             w_take_in;
   logic [7:0]       w_in_byte;
   logic [CRC_W-1:0] w_step;
   logic [CRC_W-1:0] w_final;
   logic [CNT_W-1:0] w_sel;
   logic [7:0]       w_crc_byte;

   assign w_slot_free = !r_axiov || axior;
   assign axiir       = r_started && w_slot_free && (r_state != ST_APPEND);
   assign w_take_in   = axiiv && axiir;
   assign w_in_byte   = REFIN ? 8'(reflect(32'(axiid), 8)) : axiid;
   assign w_final     = (REFOUT ? CRC_W'(reflect(32'(w_step), CRC_W)) : w_step) ^ XOROUT;

   // CRC bytes go out LSByte first when the result is reflected, MSByte first otherwise
   assign w_sel      = REFOUT ? r_cnt : CNT_W'(NB - 1) - r_cnt;
   assign w_crc_byte = 8'(r_crc_value >> {w_sel, 3'b000});

   crc_byte_step #(
      .CRC_W (CRC_W),
      .POLY  (POLY)
   ) u_step (
      .i_crc   (r_crc),
      .i_byte  (w_in_byte),
      .o_crc_c (w_step)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= ST_IDLE;
         r_started   <= 1'b0;
         r_crc       <= INIT;
         r_crc_value <= '0;
         r_cnt       <= '0;
         r_axiov     <= 1'b0;
         r_axiod     <= '0;
         r_axiol     <= 1'b0;
         r_crc_ok    <= 1'b0;
         r_crc_err   <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_started   <= 1'b1;
         r_crc       <= w_crc_nxt;
         r_crc_value <= w_crc_value_nxt;
         r_cnt       <= w_cnt_nxt;
         r_axiov     <= w_axiov_nxt;
         r_axiod     <= w_axiod_nxt;
         r_axiol     <= w_axiol_nxt;
         r_crc_ok    <= w_crc_ok_nxt;
         r_crc_err   <= w_crc_err_nxt;
      end
   end

   // Next state, CRC register and output beat
   always_comb begin
      w_state_nxt     = r_state;
      w_crc_nxt       = r_crc;
      w_crc_value_nxt = r_crc_value;
      w_cnt_nxt       = r_cnt;
      w_axiov_nxt     = r_axiov;
      w_axiod_nxt     = r_axiod;
      w_axiol_nxt     = r_axiol;
      w_crc_ok_nxt    = r_crc_ok;
      w_crc_err_nxt   = r_crc_err;

      if (w_slot_free) begin
         w_axiov_nxt   = 1'b0;
         w_axiol_nxt   = 1'b0;
         w_crc_ok_nxt  = 1'b0;
         w_crc_err_nxt = 1'b0;
      end

      if (r_state == ST_APPEND) begin
         if (w_slot_free) begin
            w_axiov_nxt = 1'b1;
            w_axiod_nxt = w_crc_byte;
            w_cnt_nxt   = r_cnt + CNT_W'(1);
            if (r_cnt == CNT_W'(NB - 1)) begin
               w_axiol_nxt = 1'b1;
               w_cnt_nxt   = '0;
               w_state_nxt = ST_IDLE;
            end
         end
      end else if (w_take_in) begin
         w_axiov_nxt = 1'b1;
         w_axiod_nxt = axiid;
         if (axiil) begin
            w_crc_nxt       = INIT;
            w_crc_value_nxt = w_final;
            if (MODE == MODE_CHECK) begin
               w_axiol_nxt   = 1'b1;
               w_crc_ok_nxt  = (w_step == RESIDUE);
               w_crc_err_nxt = (w_step != RESIDUE);
               w_state_nxt   = ST_IDLE;
            end else begin
               w_state_nxt = ST_APPEND;
            end
         end else begin
            w_crc_nxt   = w_step;
            w_state_nxt = ST_DATA;
         end
      end
   end

   assign axiov     = r_axiov;
   assign axiod     = r_axiod;
   assign axiol     = r_axiol;
   assign crc_value = r_crc_value;
   assign crc_ok    = r_crc_ok;
   assign crc_err   = r_crc_err;

endmodule

// File: tb/tb_crc_stream.sv
// Directed bench for crc_stream: four instances (CRC8 append/check, CRC16, CRC32)
// driven through one shared stream interface selected by sel.
module tb_crc_stream;
   import crc_pkg::*;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       axiiv = 1'b0;
   logic       axiil = 1'b0;
   logic       axior = 1'b1;
   logic [7:0] axiid = 8'h00;
   int         sel = 0;

   logic       iv [4];
   logic       ir [4];
   logic       ov [4];
   logic [7:0] od [4];
   logic       ol [4];
   logic       ok [4];
   logic       er [4];
   logic [7:0]  cv0, cv1;
   logic [15:0] cv2;
   logic [31:0] cv3;

   logic        o_r, o_v, o_l, o_ok, o_err;
   logic [7:0]  o_d;
   logic [31:0] o_cv;

   typedef struct packed {logic [7:0] d; logic l; logic ok; logic err;} beat_t;
   typedef struct packed {logic [7:0] d; logic l;} tx_t;
   beat_t got_q[$];
   beat_t exp_q[$];
   tx_t   tx_q[$];
   int    n_chk = 0;
   int    n_pass = 0;

   always #5 clk = ~clk;

   for (genvar k = 0; k < 4; k++) begin : g_iv
      assign iv[k] = axiiv && (sel == k);
   end

   crc_stream #(.CRC_W(CRC8_W), .POLY(CRC8_POLY), .INIT(CRC8_INIT), .REFIN(CRC8_REFIN),
      .REFOUT(CRC8_REFOUT), .XOROUT(CRC8_XOROUT), .RESIDUE(CRC8_RESIDUE), .MODE(MODE_APPEND))
   u_dut0 (.clk(clk), .rst_n(rst_n), .axiiv(iv[0]), .axiid(axiid), .axiil(axiil), .axiir(ir[0]),
      .axiov(ov[0]), .axiod(od[0]), .axiol(ol[0]), .axior(axior), .crc_value(cv0),
      .crc_ok(ok[0]), .crc_err(er[0]));

   crc_stream #(.CRC_W(CRC8_W), .POLY(CRC8_POLY), .INIT(CRC8_INIT), .REFIN(CRC8_REFIN),
      .REFOUT(CRC8_REFOUT), .XOROUT(CRC8_XOROUT), .RESIDUE(CRC8_RESIDUE), .MODE(MODE_CHECK))
   u_dut1 (.clk(clk), .rst_n(rst_n), .axiiv(iv[1]), .axiid(axiid), .axiil(axiil), .axiir(ir[1]),
      .axiov(ov[1]), .axiod(od[1]), .axiol(ol[1]), .axior(axior), .crc_value(cv1),
      .crc_ok(ok[1]), .crc_err(er[1]));

   crc_stream #(.CRC_W(CRC16_W), .POLY(CRC16_POLY), .INIT(CRC16_INIT), .REFIN(CRC16_REFIN),
      .REFOUT(CRC16_REFOUT), .XOROUT(CRC16_XOROUT), .RESIDUE(CRC16_RESIDUE), .MODE(MODE_APPEND))
   u_dut2 (.clk(clk), .rst_n(rst_n), .axiiv(iv[2]), .axiid(axiid), .axiil(axiil), .axiir(ir[2]),
      .axiov(ov[2]), .axiod(od[2]), .axiol(ol[2]), .axior(axior), .crc_value(cv2),
      .crc_ok(ok[2]), .crc_err(er[2]));

   crc_stream #(.CRC_W(CRC32_W), .POLY(CRC32_POLY), .INIT(CRC32_INIT), .REFIN(CRC32_REFIN),
      .REFOUT(CRC32_REFOUT), .XOROUT(CRC32_XOROUT), .RESIDUE(CRC32_RESIDUE), .MODE(MODE_APPEND))
   u_dut3 (.clk(clk), .rst_n(rst_n), .axiiv(iv[3]), .axiid(axiid), .axiil(axiil), .axiir(ir[3]),
      .axiov(ov[3]), .axiod(od[3]), .axiol(ol[3]), .axior(axior), .crc_value(cv3),
      .crc_ok(ok[3]), .crc_err(er[3]));

   always_comb begin
      o_r = ir[0]; o_v = ov[0]; o_d = od[0]; o_l = ol[0]; o_ok = ok[0]; o_err = er[0];
      o_cv = 32'(cv0);
      case (sel)
         1: begin o_r = ir[1]; o_v = ov[1]; o_d = od[1]; o_l = ol[1]; o_ok = ok[1]; o_err = er[1]; o_cv = 32'(cv1); end
         2: begin o_r = ir[2]; o_v = ov[2]; o_d = od[2]; o_l = ol[2]; o_ok = ok[2]; o_err = er[2]; o_cv = 32'(cv2); end
         3: begin o_r = ir[3]; o_v = ov[3]; o_d = od[3]; o_l = ol[3]; o_ok = ok[3]; o_err = er[3]; o_cv = 32'(cv3); end
         default: ;
      endcase
   end

   // Inputs change just after posedge, so mid-cycle shows the coming handshake
   always @(negedge clk) begin
      if (o_v && axior) got_q.push_back('{d: o_d, l: o_l, ok: o_ok, err: o_err});
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   task automatic add_byte(input logic [7:0] d, input logic tx_last, input logic exp_last,
                           input logic exp_ok, input logic exp_err);
      tx_q.push_back('{d: d, l: tx_last});
      exp_q.push_back('{d: d, l: exp_last, ok: exp_ok, err: exp_err});
   endtask

   task automatic add_data(input string s, input logic mark_last);
      for (int i = 0; i < s.len(); i++)
         add_byte(s[i], mark_last && (i == s.len() - 1), 1'b0, 1'b0, 1'b0);
   endtask

   task automatic add_exp(input logic [7:0] d, input logic last);
      exp_q.push_back('{d: d, l: last, ok: 1'b0, err: 1'b0});
   endtask

   // Called just after a posedge; returns just after the accepting posedge
   task automatic send_byte(input logic [7:0] d, input logic last);
      int t;
      t = 0;
      axiiv = 1'b1; axiid = d; axiil = last;
      forever begin
         @(negedge clk);
         if (o_r) break;
         t++;
         if (t > 100) begin
            chk("send_timeout", 32'd0, 32'd1);
            break;
         end
      end
      @(posedge clk); #1;
      axiiv = 1'b0; axiil = 1'b0;
   endtask

   task automatic send_all();
      tx_t t;
      while (tx_q.size() > 0) begin
         t = tx_q.pop_front();
         send_byte(t.d, t.l);
      end
   endtask

   task automatic drain_cmp(input string tag);
      int t;
      int n;
      t = 0;
      while (got_q.size() < exp_q.size() && t < 80) begin
         @(posedge clk); #1;
         t++;
      end
      repeat (6) @(posedge clk);
      #1;
      chk($sformatf("%s_count", tag), 32'(got_q.size()), 32'(exp_q.size()));
      n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
      for (int i = 0; i < n; i++) begin
         chk($sformatf("%s_d%0d", tag, i), 32'(got_q[i].d), 32'(exp_q[i].d));
         chk($sformatf("%s_l%0d", tag, i), 32'(got_q[i].l), 32'(exp_q[i].l));
         chk($sformatf("%s_ok%0d", tag, i), 32'(got_q[i].ok), 32'(exp_q[i].ok));
         chk($sformatf("%s_err%0d", tag, i), 32'(got_q[i].err), 32'(exp_q[i].err));
      end
      got_q.delete();
      exp_q.delete();
   endtask

   task automatic chk_zero(input string tag);
      for (int k = 0; k < 4; k++) begin
         sel = k; #1;
         chk($sformatf("%s_ir%0d", tag, k), 32'(o_r), 32'd0);
         chk($sformatf("%s_ov%0d", tag, k), 32'(o_v), 32'd0);
         chk($sformatf("%s_od%0d", tag, k), 32'(o_d), 32'd0);
         chk($sformatf("%s_ol%0d", tag, k), 32'(o_l), 32'd0);
         chk($sformatf("%s_cv%0d", tag, k), o_cv, 32'd0);
         chk($sformatf("%s_okerr%0d", tag, k), 32'({o_ok, o_err}), 32'd0);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int t;
      repeat (3) @(negedge clk);
      chk_zero("reset");

      // Ready stays low until the first edge after release
      sel = 0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      #1 chk("rdy_before_edge", 32'(o_r), 32'd0);
      @(posedge clk); #1;
      chk("rdy_after_edge", 32'(o_r), 32'd1);

      sel = 0;
      add_data("123456789", 1'b1); add_exp(8'h97, 1'b1);
      send_all(); drain_cmp("crc8_app");
      chk("crc8_value", o_cv, 32'h97);

      sel = 2;
      add_data("123456789", 1'b1); add_exp(8'h29, 1'b0); add_exp(8'hB1, 1'b1);
      send_all(); drain_cmp("crc16_app");
      chk("crc16_value", o_cv, 32'h29B1);

      sel = 3;
      add_data("123456789", 1'b1);
      add_exp(8'h26, 1'b0); add_exp(8'h39, 1'b0); add_exp(8'hF4, 1'b0); add_exp(8'hCB, 1'b1);
      send_all(); drain_cmp("crc32_app");
      chk("crc32_value", o_cv, 32'hCBF43926);

      sel = 1;
      add_data("123456789", 1'b0); add_byte(8'h97, 1'b1, 1'b1, 1'b1, 1'b0);
      send_all(); drain_cmp("crc8_chk_good");
      chk("crc8_chk_value", o_cv, 32'h00);
      add_data("023456789", 1'b0); add_byte(8'h97, 1'b1, 1'b1, 1'b0, 1'b1);
      send_all(); drain_cmp("crc8_chk_bad");

      // Stall the second CRC byte for three cycles
      sel = 2;
      add_data("123456789", 1'b1); add_exp(8'h29, 1'b0); add_exp(8'hB1, 1'b1);
      send_all();
      t = 0;
      while (!(o_v && o_l) && t < 20) begin
         @(posedge clk); #1;
         t++;
      end
      chk("stall_found_last", 32'(o_v && o_l), 32'd1);
      axior = 1'b0;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         chk($sformatf("stall_d%0d", c), 32'(o_d), 32'hB1);
         chk($sformatf("stall_l%0d", c), 32'(o_l), 32'd1);
         chk($sformatf("stall_v%0d", c), 32'(o_v), 32'd1);
         chk($sformatf("stall_ir%0d", c), 32'(o_r), 32'd0);
      end
      @(posedge clk); #1;
      axior = 1'b1;
      drain_cmp("crc16_stall");

      sel = 0;
      add_data("1", 1'b1); add_exp(8'h7E, 1'b1);
      add_data("123456789", 1'b1); add_exp(8'h97, 1'b1);
      send_all(); drain_cmp("b2b");
      chk("b2b_value", o_cv, 32'h97);

      // Abort a frame with reset, then run a clean frame
      sel = 0;
      add_data("1234", 1'b0);
      send_all();
      rst_n = 1'b0;
      @(negedge clk);
      chk_zero("midrst");
      sel = 0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      got_q.delete(); exp_q.delete();
      add_data("123456789", 1'b1); add_exp(8'h97, 1'b1);
      send_all(); drain_cmp("after_rst");
      chk("after_rst_value", o_cv, 32'h97);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/crc_stream.md
# crc_stream

Parametrised streaming CRC engine that generalises the fixed CRC8 byte engine to any byte-multiple CRC width and any Rocksoft-model polynomial. It also adds frame awareness and valid/ready flow control. In APPEND mode it passes a byte stream through and emits the CRC bytes after the last data byte. In CHECK mode it passes a stream that already ends in its CRC bytes and flags the frame good or bad. It sits between the framer and the line encoder on transmit, and in mirror position on receive.

## Interface
- CRC_W, 8: CRC width in bits; must be 8, 16 or 32.
- POLY, 8'h1D: generator polynomial, normal form, implicit top bit omitted.
- INIT, 8'hFF: register value at frame start.
- REFIN, 1: reflect each input byte before it enters the engine.
- REFOUT, 1: reflect the final register.
- XOROUT, 8'h00: XOR applied after REFOUT.
- RESIDUE, 8'h00: expected raw register after a good codeword (non-reflected, pre-XOROUT); used in CHECK mode.
- MODE, 0: 0 = APPEND, 1 = CHECK.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset; asynchronous, active-low.
- axiiv  in  1  input byte valid.
- axiid  in  8  input byte.
- axiil  in  1  last byte of frame; qualified by axiiv.
- axiir  out  1  input ready.
- axiov  out  1  output byte valid.
- axiod  out  8  output byte.
- axiol  out  1  last output byte of frame.
- axior  in  1  downstream ready.
- crc_value  out  CRC_W  final CRC of the last completed frame (post REFOUT/XOROUT).
- crc_ok  out  1  CHECK mode: 1 on the axiol beat if the residue matched; always 0 in APPEND mode.
- crc_err  out  1  CHECK mode: 1 on the axiol beat if the residue mismatched; always 0 in APPEND mode.

## Operation
- A byte is accepted when axiiv && axiir. A byte is emitted when axiov && axior.
- On reset: CRC register = INIT; state = IDLE; all outputs 0, including axiir.
- After reset, axiir rises on the first clk edge after rst_n is released.
- States:
  - IDLE: no frame open.
  - DATA: frame open.
  - APPEND: emitting CRC bytes; APPEND mode only.
- IDLE→DATA: on the first accepted byte. If that byte carries axiil, go straight to end-of-frame handling, so a 1-byte frame is legal.
- Every accepted byte updates the register with one full byte step (8 LFSR shifts, MSB-first after optional REFIN). It is forwarded unchanged to axiod.
- End of frame in APPEND mode:
  - On the accepted axiil byte, the forwarded byte has axiol = 0, and the state moves to APPEND.
  - APPEND emits CRC_W/8 bytes of the final CRC: LSByte first if REFOUT = 1, MSByte first otherwise.
  - axiol = 1 on the final CRC byte only. axiir = 0 throughout APPEND.
  - After the last CRC byte is taken, the state returns to IDLE.
- End of frame in CHECK mode:
  - The axiil byte is forwarded with axiol = 1.
  - crc_ok/crc_err are evaluated on the post-update register and presented with that beat.
  - The state returns to IDLE.
- crc_value updates when the last frame byte is accepted and holds until the next frame end.
- The register reloads INIT on frame end. A back-to-back frame needs no idle cycle.
- Reset mid-frame aborts: the partial frame and any pending APPEND bytes are discarded, and nothing is flagged.

## Timing
- One output register; input-to-output latency is 1 cycle.
- axiir = (!axiov || axior) && state != APPEND. This is combinational, giving full throughput of 1 byte/cycle when axior = 1.
- With axior = 0, axiod, axiol, crc_ok and crc_err hold stable until the beat is taken.
- A frame of N bytes occupies the output for N + CRC_W/8 cycles in APPEND mode and N cycles in CHECK mode.
- The last data byte and the first CRC byte are on consecutive cycles when axior = 1.
- axiiv arriving during APPEND is not accepted. The source holds it until axiir returns.

## Structure
- Package crc_pkg holds:
  - the state enum;
  - the MODE constants;
  - a bit-reflect function;
  - preset constant sets: CRC8 (0x1D/FF/ref/00); CRC16-CCITT-FALSE (0x1021/FFFF/noref/0000); CRC32 (0x04C11DB7/FFFFFFFF/ref/FFFFFFFF, residue 0xDEBB20E3).
- Sub-module crc_byte_step: combinational, parametrised by CRC_W and POLY. It maps (register, byte) to the next register and is instantiated once.

## Test plan
- CRC8 preset, APPEND, "123456789" with axiil on '9' → bytes forwarded, then 0x97 with axiol; crc_value = 0x97.
- CRC32 preset, APPEND, same string → appended bytes 26 39 F4 CB in order; CRC16-CCITT-FALSE → 29 B1.
- CRC8 preset, CHECK, "123456789" + 0x97 → crc_ok = 1 on the axiol beat; flip one data bit → crc_err = 1, crc_ok = 0.
- APPEND with axior held low for 3 cycles during the second CRC byte → the byte is held stable, axiir stays 0, and no byte is lost or duplicated.
- Two back-to-back frames ("1" then "123456789") with no gap, CRC8 → both CRCs correct; the register reloads INIT between frames.
- rst_n pulsed low mid-frame and then released → all outputs 0 during reset; the next full frame produces the correct CRC.
